// File: rtl/yuv2rgb_pipe.sv
// YCbCr to RGB converter with selectable BT.601/BT.709 limited/full matrices.
// Four-stage datapath, plus one chroma look-ahead stage for 4:2:2 input.
module yuv2rgb_pipe #(
  parameter int DATA_W = 8,
  parameter int IN_422 = 0,
  parameter int FRAC_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              vs_i,
  input  logic              hs_i,
  input  logic              de_i,
  input  logic [DATA_W-1:0] y_ch_i,
  input  logic [DATA_W-1:0] u_ch_i,
  input  logic [DATA_W-1:0] v_ch_i,
  input  logic [1:0]        mode_i,
  output logic              vs_o,
  output logic              hs_o,
  output logic              de_o,
  output logic [DATA_W-1:0] r_o,
  output logic [DATA_W-1:0] g_o,
  output logic [DATA_W-1:0] b_o,
  output logic [1:0]        mode_o
);

  localparam int CW = DATA_W + 2;
  localparam int KW = FRAC_W + 3;
  localparam int PW = CW + KW;
  localparam int SW = PW + 2;
  localparam logic [DATA_W-1:0]    COFF     = DATA_W'(128 << (DATA_W - 8));
  localparam logic [DATA_W-1:0]    YOFF_LIM = DATA_W'(16 << (DATA_W - 8));
  localparam logic signed [SW-1:0] RND      = SW'(2 ** (FRAC_W - 1));
  localparam logic signed [SW-1:0] MAXS     = SW'(2 ** DATA_W - 1);

  // Coefficients are tabulated with 10 fraction bits; rescale to FRAC_W.
  function automatic logic signed [KW-1:0] kscale(input int k);
    int up;
    int dn;
    up = (FRAC_W >= 10) ? FRAC_W - 10 : 0;
    dn = (FRAC_W < 10) ? 10 - FRAC_W : 0;
    return KW'(((k <<< up) + ((1 <<< dn) >>> 1)) >>> dn);
  endfunction

  function automatic logic [DATA_W-1:0] clamp(input logic signed [SW-1:0] s);
    if (s[SW-1])
      return '0;
    else if (s > MAXS)
      return '1;
    else
      return s[DATA_W-1:0];
  endfunction

  // Mode is only sampled on a vs rising edge, then travels with the pixels.
  logic       r_vs_prev;
  logic [1:0] r_mode_lat;
  logic       w_vs_rise;
  logic [1:0] w_mode_in;

  assign w_vs_rise = vs_i & ~r_vs_prev;
  assign w_mode_in = w_vs_rise ? mode_i : r_mode_lat;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vs_prev  <= 1'b0;
      r_mode_lat <= 2'd0;
    end else begin
      r_vs_prev <= vs_i;
      if (w_vs_rise)
        r_mode_lat <= mode_i;
    end
  end

  logic              w_f_vs;
  logic              w_f_hs;
  logic              w_f_de;
  logic [DATA_W-1:0] w_f_y;
  logic [DATA_W-1:0] w_f_cb;
  logic [DATA_W-1:0] w_f_cr;
  logic [1:0]        w_f_mode;

  generate
    if (IN_422 != 0) begin : g_422
      logic              r_phase;
      logic              r_s0_vs;
      logic              r_s0_hs;
      logic              r_s0_de;
      logic              r_s0_phase;
      logic [DATA_W-1:0] r_s0_y;
      logic [DATA_W-1:0] r_s0_u;
      logic [1:0]        r_s0_mode;
      logic [DATA_W-1:0] r_cb_hold;
      logic [DATA_W-1:0] r_cr_hold;
      logic              w_in_phase;
      logic              w_unused_v;

      assign w_unused_v = ^v_ch_i;
      // r_s0_de is the previous de_i, so this detects the de rising edge.
      assign w_in_phase = (de_i && !r_s0_de) ? 1'b0 : r_phase;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_phase    <= 1'b0;
          r_s0_vs    <= 1'b0;
          r_s0_hs    <= 1'b0;
          r_s0_de    <= 1'b0;
          r_s0_phase <= 1'b0;
          r_s0_y     <= '0;
          r_s0_u     <= '0;
          r_s0_mode  <= 2'd0;
          r_cb_hold  <= COFF;
          r_cr_hold  <= COFF;
        end else begin
          if (de_i)
            r_phase <= ~w_in_phase;
          r_s0_vs    <= vs_i;
          r_s0_hs    <= hs_i;
          r_s0_de    <= de_i;
          r_s0_phase <= w_in_phase;
          r_s0_y     <= y_ch_i;
          r_s0_u     <= u_ch_i;
          r_s0_mode  <= w_mode_in;
          // Blanking forgets the last Cr so a lone first pixel gets Coff.
          if (!r_s0_de)
            r_cr_hold <= COFF;
          else if (r_s0_phase)
            r_cr_hold <= r_s0_u;
          if (r_s0_de && !r_s0_phase)
            r_cb_hold <= r_s0_u;
        end
      end

      assign w_f_vs   = r_s0_vs;
      assign w_f_hs   = r_s0_hs;
      assign w_f_de   = r_s0_de;
      assign w_f_y    = r_s0_y;
      assign w_f_mode = r_s0_mode;
      assign w_f_cb   = r_s0_phase ? r_cb_hold : r_s0_u;
      // Phase-0 pixel takes its partner's Cr from the live input when present.
      assign w_f_cr   = r_s0_phase ? r_s0_u : (de_i ? u_ch_i : r_cr_hold);
    end else begin : g_444
      assign w_f_vs   = vs_i;
      assign w_f_hs   = hs_i;
      assign w_f_de   = de_i;
      assign w_f_y    = y_ch_i;
      assign w_f_cb   = u_ch_i;
      assign w_f_cr   = v_ch_i;
      assign w_f_mode = w_mode_in;
    end
  endgenerate

  // S1: offset subtract
  logic                 r_s1_vs;
  logic                 r_s1_hs;
  logic                 r_s1_de;
  logic [1:0]           r_s1_mode;
  logic signed [CW-1:0] r_s1_y;
  logic signed [CW-1:0] r_s1_u;
  logic signed [CW-1:0] r_s1_v;
  logic [DATA_W-1:0]    w_yoff;

  assign w_yoff = w_f_mode[0] ? '0 : YOFF_LIM;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_vs   <= 1'b0;
      r_s1_hs   <= 1'b0;
      r_s1_de   <= 1'b0;
      r_s1_mode <= 2'd0;
      r_s1_y    <= '0;
      r_s1_u    <= '0;
      r_s1_v    <= '0;
    end else begin
      r_s1_vs   <= w_f_vs;
      r_s1_hs   <= w_f_hs;
      r_s1_de   <= w_f_de;
      r_s1_mode <= w_f_mode;
      r_s1_y    <= $signed({2'b00, w_f_y}) - $signed({2'b00, w_yoff});
      r_s1_u    <= $signed({2'b00, w_f_cb}) - $signed({2'b00, COFF});
      r_s1_v    <= $signed({2'b00, w_f_cr}) - $signed({2'b00, COFF});
    end
  end

  // S2: multiply
  logic signed [KW-1:0] w_ky;
  logic signed [KW-1:0] w_krv;
  logic signed [KW-1:0] w_kgu;
  logic signed [KW-1:0] w_kgv;
  logic signed [KW-1:0] w_kbu;

  always_comb begin
    w_ky  = kscale(1192);
    w_krv = kscale(1634);
    w_kgu = kscale(401);
    w_kgv = kscale(833);
    w_kbu = kscale(2066);
    case (r_s1_mode)
      2'd1: begin
        w_ky  = kscale(1024);
        w_krv = kscale(1436);
        w_kgu = kscale(352);
        w_kgv = kscale(731);
        w_kbu = kscale(1815);
      end
      2'd2: begin
        w_ky  = kscale(1192);
        w_krv = kscale(1836);
        w_kgu = kscale(218);
        w_kgv = kscale(546);
        w_kbu = kscale(2163);
      end
      2'd3: begin
        w_ky  = kscale(1024);
        w_krv = kscale(1613);
        w_kgu = kscale(192);
        w_kgv = kscale(479);
        w_kbu = kscale(1900);
      end
      default: ;
    endcase
  end

  logic                 r_s2_vs;
  logic                 r_s2_hs;
  logic                 r_s2_de;
  logic [1:0]           r_s2_mode;
  logic signed [PW-1:0] r_s2_yy;
  logic signed [PW-1:0] r_s2_rv;
  logic signed [PW-1:0] r_s2_gu;
  logic signed [PW-1:0] r_s2_gv;
  logic signed [PW-1:0] r_s2_bu;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s2_vs   <= 1'b0;
      r_s2_hs   <= 1'b0;
      r_s2_de   <= 1'b0;
      r_s2_mode <= 2'd0;
      r_s2_yy   <= '0;
      r_s2_rv   <= '0;
      r_s2_gu   <= '0;
      r_s2_gv   <= '0;
      r_s2_bu   <= '0;
    end else begin
      r_s2_vs   <= r_s1_vs;
      r_s2_hs   <= r_s1_hs;
      r_s2_de   <= r_s1_de;
      r_s2_mode <= r_s1_mode;
      r_s2_yy   <= PW'(r_s1_y) * PW'(w_ky);
      r_s2_rv   <= PW'(r_s1_v) * PW'(w_krv);
      r_s2_gu   <= PW'(r_s1_u) * PW'(w_kgu);
      r_s2_gv   <= PW'(r_s1_v) * PW'(w_kgv);
      r_s2_bu   <= PW'(r_s1_u) * PW'(w_kbu);
    end
  end

  // S3: sum and round
  logic signed [SW-1:0] w_r_sum;
  logic signed [SW-1:0] w_g_sum;
  logic signed [SW-1:0] w_b_sum;

  assign w_r_sum = SW'(r_s2_yy) + SW'(r_s2_rv) + RND;
  assign w_g_sum = SW'(r_s2_yy) - SW'(r_s2_gu) - SW'(r_s2_gv) + RND;
  assign w_b_sum = SW'(r_s2_yy) + SW'(r_s2_bu) + RND;

  logic                 r_s3_vs;
  logic                 r_s3_hs;
  logic                 r_s3_de;
  logic [1:0]           r_s3_mode;
  logic signed [SW-1:0] r_s3_r;
  logic signed [SW-1:0] r_s3_g;
  logic signed [SW-1:0] r_s3_b;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s3_vs   <= 1'b0;
      r_s3_hs   <= 1'b0;
      r_s3_de   <= 1'b0;
      r_s3_mode <= 2'd0;
      r_s3_r    <= '0;
      r_s3_g    <= '0;
      r_s3_b    <= '0;
    end else begin
      r_s3_vs   <= r_s2_vs;
      r_s3_hs   <= r_s2_hs;
      r_s3_de   <= r_s2_de;
      r_s3_mode <= r_s2_mode;
      r_s3_r    <= w_r_sum >>> FRAC_W;
      r_s3_g    <= w_g_sum >>> FRAC_W;
      r_s3_b    <= w_b_sum >>> FRAC_W;
    end
  end

  // S4: clamp, blank outside active video, register outputs
  logic              r_s4_vs;
  logic              r_s4_hs;
  logic              r_s4_de;
  logic [1:0]        r_s4_mode;
  logic [DATA_W-1:0] r_s4_r;
  logic [DATA_W-1:0] r_s4_g;
  logic [DATA_W-1:0] r_s4_b;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s4_vs   <= 1'b0;
      r_s4_hs   <= 1'b0;
      r_s4_de   <= 1'b0;
      r_s4_mode <= 2'd0;
      r_s4_r    <= '0;
      r_s4_g    <= '0;
      r_s4_b    <= '0;
    end else begin
      r_s4_vs   <= r_s3_vs;
      r_s4_hs   <= r_s3_hs;
      r_s4_de   <= r_s3_de;
      r_s4_mode <= r_s3_mode;
      r_s4_r    <= r_s3_de ? clamp(r_s3_r) : '0;
      r_s4_g    <= r_s3_de ? clamp(r_s3_g) : '0;
      r_s4_b    <= r_s3_de ? clamp(r_s3_b) : '0;
    end
  end

  assign vs_o   = r_s4_vs;
  assign hs_o   = r_s4_hs;
  assign de_o   = r_s4_de;
  assign mode_o = r_s4_mode;
  assign r_o    = r_s4_r;
  assign g_o    = r_s4_g;
  assign b_o    = r_s4_b;

endmodule

// File: tb/tb_yuv2rgb_pipe.sv
// Directed bench for yuv2rgb_pipe: one 4:4:4 instance and one 4:2:2 instance,
// both 8-bit, checked against hand-computed RGB values.
module tb_yuv2rgb_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       a_vs = 1'b0, a_hs = 1'b0, a_de = 1'b0;
  logic [7:0] a_y = 8'd0, a_u = 8'd0, a_v = 8'd0;
  logic [1:0] a_mode = 2'd0;
  logic       a_vs_o, a_hs_o, a_de_o;
  logic [7:0] a_r_o, a_g_o, a_b_o;
  logic [1:0] a_mode_o;

  logic       b_vs = 1'b0, b_hs = 1'b0, b_de = 1'b0;
  logic [7:0] b_y = 8'd0, b_u = 8'd0, b_v = 8'd0;
  logic [1:0] b_mode = 2'd0;
  logic       b_vs_o, b_hs_o, b_de_o;
  logic [7:0] b_r_o, b_g_o, b_b_o;
  logic [1:0] b_mode_o;

  int n_checks = 0;
  int n_fail   = 0;

  // 4:2:2 stream: 4-pixel line, 1-cycle gap, 3-pixel line, gap, 1-pixel line
  bit         st_de [20] = '{1,1,1,1,0,1,1,1,0,1,0,0,0,0,0,0,0,0,0,0};
  logic [7:0] st_u  [20] = '{8'd160, 8'd96, 8'd100, 8'd200, 8'd0,
                             8'd160, 8'd96, 8'd100, 8'd0, 8'd160,
                             8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                             8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
  logic [23:0] ex_rgb [20] = '{{8'd79, 8'd144, 8'd195}, {8'd79, 8'd144, 8'd195},
                               {8'd245, 8'd83, 8'd74}, {8'd245, 8'd83, 8'd74},
                               24'd0,
                               {8'd79, 8'd144, 8'd195}, {8'd79, 8'd144, 8'd195},
                               {8'd79, 8'd167, 8'd74},
                               24'd0,
                               {8'd130, 8'd118, 8'd195},
                               24'd0, 24'd0, 24'd0, 24'd0, 24'd0,
                               24'd0, 24'd0, 24'd0, 24'd0, 24'd0};

  always #5 clk = ~clk;

  yuv2rgb_pipe #(.DATA_W(8), .IN_422(0), .FRAC_W(10)) u_dut444 (
    .clk_i(clk), .rst_i(rst),
    .vs_i(a_vs), .hs_i(a_hs), .de_i(a_de),
    .y_ch_i(a_y), .u_ch_i(a_u), .v_ch_i(a_v), .mode_i(a_mode),
    .vs_o(a_vs_o), .hs_o(a_hs_o), .de_o(a_de_o),
    .r_o(a_r_o), .g_o(a_g_o), .b_o(a_b_o), .mode_o(a_mode_o)
  );

  yuv2rgb_pipe #(.DATA_W(8), .IN_422(1), .FRAC_W(10)) u_dut422 (
    .clk_i(clk), .rst_i(rst),
    .vs_i(b_vs), .hs_i(b_hs), .de_i(b_de),
    .y_ch_i(b_y), .u_ch_i(b_u), .v_ch_i(b_v), .mode_i(b_mode),
    .vs_o(b_vs_o), .hs_o(b_hs_o), .de_o(b_de_o),
    .r_o(b_r_o), .g_o(b_g_o), .b_o(b_b_o), .mode_o(b_mode_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated 4:4:4 pixel: checks latency 4, value, mode and blanking after.
  task automatic pix444(input string tag, input logic [7:0] y, input logic [7:0] u,
                        input logic [7:0] v, input logic [23:0] exp_rgb,
                        input logic [1:0] exp_mode);
    a_de = 1'b1; a_y = y; a_u = u; a_v = v;
    step();
    a_de = 1'b0; a_y = 8'd0; a_u = 8'd0; a_v = 8'd0;
    step();
    step();
    chk({tag, "_lat3"}, 32'(a_de_o), 32'd0);
    step();
    chk({tag, "_de"}, 32'(a_de_o), 32'd1);
    chk({tag, "_rgb"}, 32'({a_r_o, a_g_o, a_b_o}), 32'(exp_rgb));
    chk({tag, "_mode"}, 32'(a_mode_o), 32'(exp_mode));
    $display("pix444 %s y=%0d u=%0d v=%0d -> r=%0d g=%0d b=%0d mode=%0d",
             tag, y, u, v, a_r_o, a_g_o, a_b_o, a_mode_o);
    step();
    chk({tag, "_blank"}, 32'({a_de_o, a_r_o, a_g_o, a_b_o}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held while a frame is driven
    for (int i = 0; i < 5; i++) begin
      a_vs = i[0]; a_de = 1'b1; a_y = 8'd235; a_u = 8'd128; a_v = 8'd128; a_mode = 2'd3;
      b_vs = i[0]; b_de = 1'b1; b_y = 8'd200; b_u = 8'd50;  b_v = 8'd90;  b_mode = 2'd3;
      step();
      chk("rst_a", 32'({a_vs_o, a_hs_o, a_de_o, a_r_o, a_g_o, a_b_o, a_mode_o}), 32'd0);
      chk("rst_b", 32'({b_vs_o, b_hs_o, b_de_o, b_r_o, b_g_o, b_b_o, b_mode_o}), 32'd0);
    end
    rst = 1'b0;
    a_vs = 1'b0; a_de = 1'b0; a_y = 8'd0; a_u = 8'd0; a_v = 8'd0; a_mode = 2'd0;
    b_vs = 1'b0; b_de = 1'b0; b_y = 8'd128; b_u = 8'd0; b_v = 8'h33; b_mode = 2'd0;

    // Mode 0 (reset default)
    pix444("m0_black", 8'd16, 8'd128, 8'd128, {8'd0, 8'd0, 8'd0}, 2'd0);
    pix444("m0_white", 8'd235, 8'd128, 8'd128, {8'd255, 8'd255, 8'd255}, 2'd0);
    pix444("m0_color", 8'd128, 8'd160, 8'd96, {8'd79, 8'd144, 8'd195}, 2'd0);

    // mode_i changes without a vs edge: no effect
    a_mode = 2'd3;
    pix444("m0_hold", 8'd128, 8'd160, 8'd96, {8'd79, 8'd144, 8'd195}, 2'd0);

    // vs rising edge latches mode 3; mode_o switches with vs_o
    a_vs = 1'b1;
    step();
    a_vs = 1'b0; a_mode = 2'd0;
    step();
    step();
    chk("vs_lat3", 32'({a_vs_o, a_mode_o}), 32'd0);
    step();
    chk("vs_edge", 32'({a_vs_o, a_mode_o}), 32'b111);
    step();
    chk("vs_fall", 32'({a_vs_o, a_mode_o}), 32'b011);
    pix444("m3_color", 8'd128, 8'd160, 8'd96, {8'd78, 8'd137, 8'd187}, 2'd3);
    pix444("m3_white", 8'd235, 8'd128, 8'd128, {8'd235, 8'd235, 8'd235}, 2'd3);

    // Mode 1 clamping cases
    a_mode = 2'd1; a_vs = 1'b1;
    step();
    a_vs = 1'b0;
    step();
    pix444("m1_clamp_hi", 8'd255, 8'd128, 8'd255, {8'd255, 8'd164, 8'd255}, 2'd1);
    pix444("m1_clamp_lo", 8'd0, 8'd0, 8'd128, {8'd0, 8'd44, 8'd0}, 2'd1);

    // hs delay
    a_hs = 1'b1;
    step();
    a_hs = 1'b0;
    step();
    step();
    chk("hs_lat3", 32'(a_hs_o), 32'd0);
    step();
    chk("hs_lat4", 32'(a_hs_o), 32'd1);
    step();
    chk("hs_fall", 32'(a_hs_o), 32'd0);

    // 4:2:2 stream, latency 5
    for (int i = 0; i < 20; i++) begin
      b_de = st_de[i];
      b_u  = st_u[i];
      step();
      if (i >= 4) begin
        chk($sformatf("b422_de%0d", i - 4), 32'(b_de_o), 32'(st_de[i - 4]));
        chk($sformatf("b422_rgb%0d", i - 4), 32'({b_r_o, b_g_o, b_b_o}), 32'(ex_rgb[i - 4]));
        if (st_de[i - 4])
          $display("pix422 idx=%0d -> r=%0d g=%0d b=%0d", i - 4, b_r_o, b_g_o, b_b_o);
      end else begin
        chk($sformatf("b422_idle%0d", i), 32'(b_de_o), 32'd0);
      end
    end
    chk("b422_mode", 32'(b_mode_o), 32'd0);

    // Reset in the middle of an active line (444 instance in mode 1)
    a_de = 1'b1; a_y = 8'd235; a_u = 8'd128; a_v = 8'd128;
    for (int i = 0; i < 5; i++) step();
    chk("midline_pre_de", 32'(a_de_o), 32'd1);
    chk("midline_pre_rgb", 32'({a_r_o, a_g_o, a_b_o}), 32'({8'd235, 8'd235, 8'd235}));
    rst = 1'b1;
    step();
    chk("midline_rst1", 32'({a_vs_o, a_hs_o, a_de_o, a_r_o, a_g_o, a_b_o, a_mode_o}), 32'd0);
    step();
    chk("midline_rst2", 32'({a_vs_o, a_hs_o, a_de_o, a_r_o, a_g_o, a_b_o, a_mode_o}), 32'd0);
    rst = 1'b0;
    a_de = 1'b0; a_y = 8'd0; a_u = 8'd0; a_v = 8'd0; a_mode = 2'd0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("post_rst_idle%0d", i), 32'({a_de_o, a_r_o, a_g_o, a_b_o, a_mode_o}), 32'd0);
    end
    pix444("post_rst", 8'd235, 8'd128, 8'd128, {8'd255, 8'd255, 8'd255}, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/yuv2rgb_pipe.md
Name: yuv2rgb_pipe

Overview:
Parametrised, frame-synchronous YCbCr-to-RGB converter for the video pipeline. It sits between the timing generator or pixel source and the RGB sink. It supports 4:4:4 and 4:2:2 input, BT.601/BT.709 matrices in limited or full range, and widths above 8 bits. Sync and data-enable signals are delayed to match the fixed data latency, so the output stream stays aligned.

Parameters:
DATA_W, 8, bits per component on input and output (8..12)
IN_422, 0, 0 = separate U/V per pixel; 1 = interleaved U/V on u_ch_i (4:2:2)
FRAC_W, 10, coefficient fraction bits (coefficients are listed at FRAC_W=10)

Ports:
clk_i  in  1  pixel clock
rst_i  in  1  synchronous reset, active-high
vs_i  in  1  vertical sync
hs_i  in  1  horizontal sync
de_i  in  1  data enable
y_ch_i  in  DATA_W  luma
u_ch_i  in  DATA_W  Cb (IN_422=1: Cb/Cr interleaved)
v_ch_i  in  DATA_W  Cr (ignored when IN_422=1)
mode_i  in  2  0=601 limited, 1=601 full, 2=709 limited, 3=709 full
vs_o  out  1  delayed vs_i
hs_o  out  1  delayed hs_i
de_o  out  1  delayed de_i
r_o  out  DATA_W  red
g_o  out  DATA_W  green
b_o  out  DATA_W  blue
mode_o  out  2  matrix currently in use

Behaviour:
- Clocking and reset: one clock domain (clk_i). rst_i is synchronous and active-high.
- Reset values: all outputs 0, mode_o=0, every pipeline stage flushed.
- Reset mid-frame: outputs are 0 from the cycle after reset is sampled. Output resumes with fresh data after the full latency once rst_i is released.
- Latency: L = 4 + IN_422 clocks, from input sample to output, identical for vs/hs/de and data.
- Throughput: one pixel per clock. There is no back-pressure.
- Mode latching:
  - mode_i is captured only on a rising edge of vs_i (vs_i=1 while the previous vs_i=0).
  - Changes to mode_i at any other time have no effect until the next vs_i rising edge.
  - mode_o shows the captured value, aligned with vs_o.
- Offsets:
  - Yoff = 16<<(DATA_W-8) in limited modes, 0 in full modes.
  - Coff = 128<<(DATA_W-8) in all modes.
  - Y' = Y - Yoff, U' = U - Coff, V' = V - Coff, all signed.
- Matrix (coefficients ×1024, as Ky, Krv, Kgu, Kgv, Kbu):
  - mode0: 1192, 1634, 401, 833, 2066
  - mode1: 1024, 1436, 352, 731, 1815
  - mode2: 1192, 1836, 218, 546, 2163
  - mode3: 1024, 1613, 192, 479, 1900
- Equations:
  - R = Ky·Y' + Krv·V'
  - G = Ky·Y' - Kgu·U' - Kgv·V'
  - B = Ky·Y' + Kbu·U'
- Rounding: add 2^(FRAC_W-1), then arithmetic shift right by FRAC_W.
- Clamp: result < 0 gives 0; result > 2^DATA_W-1 gives 2^DATA_W-1. Accumulators must be wide enough that overflow never occurs before the clamp.
- Pipeline stages:
  - S1: offset subtract.
  - S2: multiply.
  - S3: sum and round.
  - S4: clamp and register outputs.
- Blanking: when de is 0 at the output stage, r_o/g_o/b_o are 0.
- 4:2:2 mode (IN_422=1):
  - A phase bit resets to 0 on each rising edge of de_i and toggles on every de_i=1 cycle.
  - Phase 0 samples Cb; phase 1 samples Cr.
  - Both pixels of a pair use the pair's Cb and Cr. The one-cycle look-ahead stage provides Cr for the phase-0 pixel.
  - Odd-length line: the last pixel has no Cr partner. It uses the previous pair's Cr, or Coff if it is the first pixel of the line.
- Back-to-back lines with de_i low for only one cycle are legal. The phase bit resets correctly.

Test Plan:
- Reset check: hold rst_i 5 cycles while driving a full frame → all outputs 0, mode_o=0. After release, first valid de_o appears exactly L cycles after the first de_i.
- mode0, DATA_W=8, IN_422=0:
  - Y=16, U=V=128 → RGB 0,0,0.
  - Y=235, U=V=128 → 255,255,255.
  - de_o is de_i delayed by 4.
- mode1 clamping:
  - Y=255, U=128, V=255 → R=255, G=164, B=255.
  - Y=0, U=0, V=128 → R=0, G=44, B=0.
- Mode latching: change mode_i from 0 to 3 mid-frame → mode_o and output values stay mode0 until the vs_o rising edge that follows the next vs_i rising edge, then use mode3.
- IN_422=1, 4-pixel line with u_ch_i=Cb0,Cr0,Cb1,Cr1 and Y constant → pixels 0/1 identical, pixels 2/3 identical, latency 5. A 3-pixel line → pixel 2 uses Cb1 and Cr0.
- Reset mid-line: assert rst_i during active video → outputs 0 from the next cycle, and no stale pixels appear after release.
